// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port fetch/data arbiter sequencing grant, access, response onto a single-port mem.
// Optional round-robin tie-break with MEM_ARB_RR_EN; default is fixed data-over-fetch priority.
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_valid,
    output logic [DW-1:0] i_data,
    output logic          i_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_valid,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    output logic [AW-1:0] m_address,
    output logic [DW-1:0] m_memIn,
    output logic          m_read,
    output logic          m_write,
    input  logic [DW-1:0] m_memOut
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] i_data_q, i_data_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic [DW-1:0] resp;
    logic          we_q, we_d;
    logic          owner_q, owner_d;
    logic          err_q, err_d;
    logic          pick_d;
    logic          can_gnt;

`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;
    assign pick_d = d_req && (!i_req || !last_q);
`else
    assign pick_d = d_req;
`endif

    assign can_gnt   = (state_q == IDLE) && !reset;
    assign i_gnt     = can_gnt && i_req && !pick_d;
    assign d_gnt     = can_gnt && pick_d;
    assign i_valid   = (state_q == RESP) && !owner_q && !reset;
    assign d_valid   = (state_q == RESP) && owner_q && !reset;
    assign i_err     = i_valid && err_q;
    assign d_err     = d_valid && err_q;
    assign i_data    = i_data_q;
    assign d_rdata   = d_rdata_q;
    assign m_address = addr_q;
    assign m_memIn   = wdata_q;
    assign m_read    = (state_q == ACCESS) && !we_q && !reset;
    assign m_write   = (state_q == ACCESS) && we_q && !reset;
    assign resp      = we_q ? '0 : m_memOut;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        owner_d   = owner_q;
        err_d     = err_q;
        i_data_d  = i_data_q;
        d_rdata_d = d_rdata_q;
`ifdef MEM_ARB_RR_EN
        last_d    = last_q;
`endif
        if (state_q == IDLE && (i_req || d_req)) begin
            owner_d = pick_d;
            addr_d  = pick_d ? d_addr : i_addr;
            wdata_d = pick_d ? d_wdata : '0;
            we_d    = pick_d && d_we;
            err_d   = addr_d[1:0] != 2'b00;
            state_d = err_d ? RESP : ACCESS;
`ifdef MEM_ARB_RR_EN
            last_d  = pick_d;
`endif
        end else if (state_q == ACCESS) begin
            d_rdata_d = owner_q ? resp : d_rdata_q;
            i_data_d  = owner_q ? i_data_q : resp;
            state_d   = RESP;
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            owner_q   <= 1'b0;
            err_q     <= 1'b0;
            i_data_q  <= '0;
            d_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            owner_q   <= owner_d;
            err_q     <= err_d;
            i_data_q  <= i_data_d;
            d_rdata_q <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_q    <= last_d;
`endif
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a behavioural single-port memory.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_gnt, i_valid, i_err, d_gnt, d_valid, d_err;
    logic [31:0] i_data, d_rdata;
    logic [31:0] m_address, m_memIn, m_memOut;
    logic        m_read, m_write;
    logic [31:0] mem [0:255];
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid), .i_data(i_data), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
        .m_address(m_address), .m_memIn(m_memIn), .m_read(m_read), .m_write(m_write), .m_memOut(m_memOut)
    );

    assign m_memOut = mem[m_address[9:2]];
    always @(posedge clk) if (m_write) mem[m_address[9:2]] <= m_memIn;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h0a] = 32'h00A00513;
        mem[8'h14] = 32'h11111111;
        reset = 1'b1; i_req = 1'b1; d_req = 1'b0; d_we = 1'b0;
        i_addr = 32'h28; d_addr = '0; d_wdata = '0;
        tick(); tick();
        #1;
        check("rst_i_gnt", i_gnt, 0);
        check("rst_m_read", m_read, 0);
        check("rst_m_write", m_write, 0);
        check("rst_i_valid", i_valid, 0);
        check("rst_i_data", i_data, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_m_address", m_address, 0);
        check("rst_m_memIn", m_memIn, 0);
        i_req = 1'b0;
        tick();
        reset = 1'b0;

        // fetch only
        i_req = 1'b1; i_addr = 32'h28; #1;
        check("f_i_gnt", i_gnt, 1);
        check("f_d_gnt", d_gnt, 0);
        tick(); i_req = 1'b0; #1;
        check("f_m_read", m_read, 1);
        check("f_m_write", m_write, 0);
        check("f_m_address", m_address, 32'h28);
        check("f_i_gnt_access", i_gnt, 0);
        tick();
        check("f_i_valid", i_valid, 1);
        check("f_i_data", i_data, 32'h00A00513);
        check("f_i_err", i_err, 0);
        check("f_d_valid", d_valid, 0);
        tick();
        check("f_i_valid_off", i_valid, 0);

        // store then load
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; #1;
        check("st_d_gnt", d_gnt, 1);
        tick(); d_req = 1'b0; #1;
        check("st_m_write", m_write, 1);
        check("st_m_read", m_read, 0);
        check("st_m_memIn", m_memIn, 32'hDEADBEEF);
        tick();
        check("st_d_valid", d_valid, 1);
        check("st_d_rdata", d_rdata, 0);
        check("st_mem", mem[8'h10], 32'hDEADBEEF);
        tick();
        d_req = 1'b1; d_we = 1'b0; #1;
        check("ld_d_gnt", d_gnt, 1);
        tick(); d_req = 1'b0; #1;
        check("ld_m_read", m_read, 1);
        tick();
        check("ld_d_valid", d_valid, 1);
        check("ld_d_rdata", d_rdata, 32'hDEADBEEF);
        check("ld_i_data_hold", i_data, 32'h00A00513);
        tick();

        // misaligned
        d_req = 1'b1; d_addr = 32'h42; #1;
        check("mis_d_gnt", d_gnt, 1);
        tick(); d_req = 1'b0; #1;
        check("mis_d_valid", d_valid, 1);
        check("mis_d_err", d_err, 1);
        check("mis_m_read", m_read, 0);
        check("mis_m_write", m_write, 0);
        tick();
        check("mis_d_valid_off", d_valid, 0);
        i_req = 1'b1; i_addr = 32'h28; #1;
        check("mis_next_gnt", i_gnt, 1);
        i_req = 1'b0;
        tick(); tick(); tick();

        // contention from a fresh reset
        reset = 1'b1; tick(); reset = 1'b0;
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 32'h28; d_addr = 32'h40; #1;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            check("ct_i_gnt", i_gnt, (k % 2 == 0) ? 1 : 0);
            check("ct_d_gnt", d_gnt, (k % 2 == 0) ? 0 : 1);
`else
            check("ct_i_gnt", i_gnt, 0);
            check("ct_d_gnt", d_gnt, 1);
`endif
            tick();
            check("ct_gap_gnt", {i_gnt, d_gnt}, 0);
            tick(); tick();
        end
        i_req = 1'b0; d_req = 1'b0;
        tick(); tick(); tick();

        // reset during store access
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h50; d_wdata = 32'hCAFEF00D; #1;
        check("rs_d_gnt", d_gnt, 1);
        tick(); d_req = 1'b0; reset = 1'b1; #1;
        check("rs_m_write", m_write, 0);
        tick(); reset = 1'b0; #1;
        check("rs_mem", mem[8'h14], 32'h11111111);
        check("rs_d_valid", d_valid, 0);
        i_req = 1'b1; #1;
        check("rs_idle_gnt", i_gnt, 1);
        tick(); i_req = 1'b0;
        tick();
        check("rs_d_valid_later", d_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the single-port `mem` block: shares one memory between the instruction-fetch requester and the load/store (data) requester. Each access is serialised as grant → access → response, with misaligned-address rejection. Sits between the CPU front/back ends and `mem`, and drives its `address`, `memIn`, `read` and `write` pins directly.

## Interface
- `AW`, 32, address width.
- `DW`, 32, data width.

Ports (name, direction, width, meaning):
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `i_req` in 1: fetch request; held until `i_gnt`.
- `i_addr` in AW: fetch address.
- `i_gnt` out 1: fetch request accepted this cycle.
- `i_valid` out 1: fetch response strobe, one cycle.
- `i_data` out DW: fetched word; valid with `i_valid`.
- `i_err` out 1: fetch misaligned; valid with `i_valid`.
- `d_req` in 1: data request; held until `d_gnt`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in AW: data address.
- `d_wdata` in DW: store data.
- `d_gnt`, `d_valid`, `d_rdata` (DW), `d_err`: out, same meaning as the `i_*` set.
- `m_address` out AW: to `mem` address.
- `m_memIn` out DW: to `mem` memIn.
- `m_read` out 1: to `mem` read.
- `m_write` out 1: to `mem` write.
- `m_memOut` in DW: from `mem` memOut (combinational read).

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If no request, stay in IDLE.
  - Otherwise select a winner and assert its gnt combinationally this cycle.
  - Latch the winner's address, we and wdata, plus an owner bit.
  - If address[1:0] ≠ 0: set err, go to RESP with no memory strobe.
  - Else go to ACCESS.
- ACCESS:
  - Drive `m_address` from the latch.
  - Load: `m_read`=1, capture `m_memOut` into the response register at the clock edge.
  - Store: `m_write`=1, `m_memIn` = latched wdata; response data = 0.
  - Go to RESP.
- RESP:
  - Owner's valid = 1 with data and err from registers; other port's valid = 0.
  - Go to IDLE.
- Arbitration default (fixed priority): data port wins when both request.
- A loser keeps its request asserted and is granted on a later IDLE cycle.
- gnt is asserted only in IDLE, and never to both ports in the same cycle.
- `m_read` and `m_write` are never both 1. Both are 0 outside ACCESS and in any cycle where `reset`=1, so no write commits during reset.
- Outside ACCESS, `m_address` and `m_memIn` hold their last values; they are don't-care.
- `i_data` and `d_rdata` hold until the next response to the same port.

## Timing
- Grant in cycle N, memory strobe in N+1, valid in N+2.
- Misaligned access: grant in N, valid + err in N+1.
- Next grant is no earlier than N+3, or N+2 after a misaligned access.
- Peak throughput: one access per 3 cycles.
- Reset values:
  - State = IDLE.
  - All gnt, valid, err, `m_read` and `m_write` = 0.
  - `i_data`, `d_rdata`, `m_address`, `m_memIn` = 0.
  - Round-robin last-winner = data, so fetch wins the first tie.
- Reset asserted in ACCESS or RESP aborts the access. No valid is issued, and the state is IDLE on the next cycle.
- A request deasserted before its gnt is simply dropped.
- Request inputs are sampled only in IDLE.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - On a tie, the port not granted last wins.
  - The last-winner register updates on every grant, misaligned grants included.
- `MEM_ARB_RR_EN` undefined: fixed data-over-fetch priority; no last-winner register.

## Test plan
- Fetch only: `i_addr`=0x28, `mem[0x28]`=0x00A00513 → `i_gnt` in cycle N, `m_read`=1 in N+1, `i_valid`=1 with `i_data`=0x00A00513 in N+2, `i_err`=0.
- Store then load: `d_we`=1, `d_addr`=0x40, `d_wdata`=0xDEADBEEF → `m_write` pulse, `d_valid` with `d_rdata`=0. Then a load from 0x40 → `d_rdata`=0xDEADBEEF.
- Misaligned: `d_addr`=0x42 → `d_gnt` in N, `d_valid`+`d_err`=1 in N+1, `m_read` and `m_write` stay 0.
- Contention: `i_req` and `d_req` held continuously.
  - Without the macro: every grant goes to data.
  - With `MEM_ARB_RR_EN`: grants alternate I, D, I, D; the first is I after reset.
- Reset mid-store: assert `reset` during ACCESS of a store to 0x50 holding 0x11111111 → `m_write`=0 that cycle, memory still 0x11111111, no `d_valid`, FSM in IDLE next cycle.
